rfifo_read_ctrl: RTL

RFIFO_READ_CTRL -- requirements
Module: rfifo_read_ctrl

---
 rtl/rfifo_read_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rfifo_read_ctrl.sv
// Read-side controller of an async FIFO: pops words into a 2-entry output buffer.
// Latency: 2 cycles from rinc to out_valid; sustains 1 word/cycle when unstalled.
// Backpressure: out_ready=0 stops popping once buffer plus in-flight word fill both slots.
module rfifo_read_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  rclk,
   input  logic                  r_nrst,
   input  logic                  empty,
   output logic                  rinc,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  enable,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pop_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
   logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
   logic [CNT_WIDTH-1:0]  pop_count_q, pop_count_d;

   logic                  xfer;
   logic                  cap;
   logic [2:0]            pending;
   logic [1:0]            base;

   // Next-state logic; a flush request overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            FLUSH:   if (empty && !inflight_q) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake and pop decision; pending counts slots still claimed after this cycle's transfer.
   always_comb begin
      out_valid = (occ_q != 2'd0) && (state_q != FLUSH);
      xfer      = out_valid && out_ready;
      cap       = inflight_q && (state_q != FLUSH);
      pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
      rinc      = 1'b0;
      case (state_q)
         RUN:     rinc = !empty && (pending < 3'd2);
         FLUSH:   rinc = !empty;
         default: rinc = 1'b0;
      endcase
   end

   // Output buffer: pop the head on transfer, then append the returning word at the new tail.
   always_comb begin
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      base     = occ_q - {1'b0, xfer};
      if (xfer) begin
         entry0_d = entry1_q;
      end
      occ_d = base;
      if (cap && (base != 2'd2)) begin
         if (base == 2'd0) begin
            entry0_d = rdata;
         end else begin
            entry1_d = rdata;
         end
         occ_d = base + 2'd1;
      end
      if (flush) begin
         occ_d = 2'd0;
      end
   end

   // A word is in flight exactly one cycle after each pop; every pop is counted.
   always_comb begin
      inflight_d  = rinc;
      pop_count_d = pop_count_q + {{(CNT_WIDTH-1){1'b0}}, rinc};
   end

   // State registers with asynchronous reset.
   always_ff @(posedge rclk or negedge r_nrst) begin
      if (!r_nrst) begin
         state_q     <= IDLE;
         occ_q       <= 2'd0;
         inflight_q  <= 1'b0;
         entry0_q    <= '0;
         entry1_q    <= '0;
         pop_count_q <= '0;
      end else begin
         state_q     <= state_d;
         occ_q       <= occ_d;
         inflight_q  <= inflight_d;
         entry0_q    <= entry0_d;
         entry1_q    <= entry1_d;
         pop_count_q <= pop_count_d;
      end
   end

   assign out_data  = entry0_q;
   assign pop_count = pop_count_q;
   assign busy      = (state_q != IDLE) || inflight_q || (occ_q != 2'd0);

endmodule
